// File: rtl/stream_receiver_ctrl.sv
// Streaming receiver controller: checks CRC-qualified packets for in-order delivery,
// writes good packets to the ZBT port and requests resends on errors or timeouts.
module stream_receiver_ctrl #(
    parameter int ADDR_W    = 19,
    parameter int DATA_W    = 36,
    parameter int CRC_W     = 16,
    parameter int MAX_RETRY = 3,
    parameter int TIMEOUT   = 1023
) (
    input  logic                            i_clk,
    input  logic                            i_reset,
    input  logic                            i_receive_en,
    input  logic                            i_pkt_valid,
    input  logic [ADDR_W+DATA_W+CRC_W-1:0]  i_pkt,
    input  logic                            i_crc_good,
    input  logic                            i_memory_full,
    input  logic                            i_wr_ready,
    output logic                            o_write_enable,
    output logic [ADDR_W-1:0]               o_zbt_address,
    output logic [DATA_W-1:0]               o_data_to_zbt,
    output logic                            o_resend_req,
    output logic [ADDR_W-1:0]               o_resend_address,
    input  logic                            i_resend_ack,
    output logic [2:0]                      o_state,
    output logic [ADDR_W-1:0]               o_expected_address,
    output logic [15:0]                     o_good_count,
    output logic [15:0]                     o_bad_count,
    output logic                            o_overflow,
    output logic                            o_link_fail
);

    localparam int PKT_W = ADDR_W + DATA_W + CRC_W;
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam int RT_W  = $clog2(MAX_RETRY + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RECEIVE = 3'd1,
        S_WRITE   = 3'd2,
        S_RESEND  = 3'd3,
        S_FAIL    = 3'd4
    } state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_exp, w_exp_nxt;
    logic [ADDR_W-1:0] r_zaddr, w_zaddr_nxt;
    logic [DATA_W-1:0] r_zdata, w_zdata_nxt;
    logic [ADDR_W-1:0] r_raddr, w_raddr_nxt;
    logic [15:0]       r_good, w_good_nxt;
    logic [15:0]       r_bad, w_bad_nxt;
    logic [RT_W-1:0]   r_retry, w_retry_nxt;
    logic [TO_W-1:0]   r_timeout, w_timeout_nxt;
    logic              r_we, w_we_nxt;
    logic              r_rreq, w_rreq_nxt;
    logic              r_ovf, w_ovf_nxt;
    logic              r_lfail, w_lfail_nxt;

    logic [ADDR_W-1:0] w_pkt_addr;
    logic [DATA_W-1:0] w_pkt_data;
    logic [TO_W-1:0]   w_timeout_inc;
    logic [RT_W-1:0]   w_retry_inc;

    // The CRC tail occupies the low bits and is simply never routed onward.
    assign w_pkt_addr    = i_pkt[PKT_W-1 -: ADDR_W];
    assign w_pkt_data    = i_pkt[CRC_W +: DATA_W];
    assign w_timeout_inc = r_timeout + TO_W'(1);
    assign w_retry_inc   = r_retry + RT_W'(1);

    // Next-state and next-output decode for the receive FSM.
    always_comb begin
        w_state_nxt   = r_state;
        w_exp_nxt     = r_exp;
        w_zaddr_nxt   = r_zaddr;
        w_zdata_nxt   = r_zdata;
        w_raddr_nxt   = r_raddr;
        w_good_nxt    = r_good;
        w_bad_nxt     = r_bad;
        w_retry_nxt   = r_retry;
        w_timeout_nxt = r_timeout;
        w_we_nxt      = r_we;
        w_rreq_nxt    = r_rreq;
        w_ovf_nxt     = r_ovf;
        w_lfail_nxt   = r_lfail;

        case (r_state)
            S_IDLE: begin
                w_timeout_nxt = '0;
                w_we_nxt      = 1'b0;
                w_rreq_nxt    = 1'b0;
                if (i_receive_en) begin
                    w_state_nxt = S_RECEIVE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RECEIVE: begin
                if (!i_receive_en) begin
                    w_state_nxt   = S_IDLE;
                    w_timeout_nxt = '0;
                end else if (i_pkt_valid) begin
                    w_timeout_nxt = '0;
                    if (i_crc_good && (w_pkt_addr == r_exp)) begin
                        if (!i_memory_full) begin
                            w_zaddr_nxt = w_pkt_addr;
                            w_zdata_nxt = w_pkt_data;
                            w_we_nxt    = 1'b1;
                            w_state_nxt = S_WRITE;
                        end else begin
                            w_ovf_nxt = 1'b1;
                            w_bad_nxt = sat_inc(r_bad);
                        end
                    end else begin
                        // Duplicates fall here too: always ask again for the expected address.
                        w_raddr_nxt = r_exp;
                        w_rreq_nxt  = 1'b1;
                        w_bad_nxt   = sat_inc(r_bad);
                        w_state_nxt = S_RESEND;
                    end
                end else if (w_timeout_inc == TO_W'(TIMEOUT)) begin
                    w_timeout_nxt = '0;
                    w_raddr_nxt   = r_exp;
                    w_rreq_nxt    = 1'b1;
                    w_state_nxt   = S_RESEND;
                end else begin
                    w_timeout_nxt = w_timeout_inc;
                end
            end
            S_WRITE: begin
                w_timeout_nxt = '0;
                if (i_pkt_valid) begin
                    w_bad_nxt = sat_inc(r_bad);
                end else begin
                    w_bad_nxt = r_bad;
                end
                if (i_wr_ready) begin
                    w_we_nxt    = 1'b0;
                    w_exp_nxt   = r_exp + ADDR_W'(1);
                    w_good_nxt  = sat_inc(r_good);
                    w_retry_nxt = '0;
                    w_state_nxt = S_RECEIVE;
                end else begin
                    w_state_nxt = S_WRITE;
                end
            end
            S_RESEND: begin
                w_timeout_nxt = '0;
                if (i_pkt_valid) begin
                    w_bad_nxt = sat_inc(r_bad);
                end else begin
                    w_bad_nxt = r_bad;
                end
                if (i_resend_ack) begin
                    w_rreq_nxt  = 1'b0;
                    w_retry_nxt = w_retry_inc;
                    if (w_retry_inc >= RT_W'(MAX_RETRY)) begin
                        w_state_nxt = S_FAIL;
                        w_lfail_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_RECEIVE;
                    end
                end else begin
                    w_state_nxt = S_RESEND;
                end
            end
            S_FAIL: begin
                w_timeout_nxt = '0;
                w_we_nxt      = 1'b0;
                w_rreq_nxt    = 1'b0;
                w_lfail_nxt   = 1'b1;
                w_state_nxt   = S_FAIL;
            end
            default: begin
                w_timeout_nxt = '0;
                w_we_nxt      = 1'b0;
                w_rreq_nxt    = 1'b0;
                w_state_nxt   = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_exp     <= '0;
            r_zaddr   <= '0;
            r_zdata   <= '0;
            r_raddr   <= '0;
            r_good    <= 16'd0;
            r_bad     <= 16'd0;
            r_retry   <= '0;
            r_timeout <= '0;
            r_we      <= 1'b0;
            r_rreq    <= 1'b0;
            r_ovf     <= 1'b0;
            r_lfail   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_exp     <= w_exp_nxt;
            r_zaddr   <= w_zaddr_nxt;
            r_zdata   <= w_zdata_nxt;
            r_raddr   <= w_raddr_nxt;
            r_good    <= w_good_nxt;
            r_bad     <= w_bad_nxt;
            r_retry   <= w_retry_nxt;
            r_timeout <= w_timeout_nxt;
            r_we      <= w_we_nxt;
            r_rreq    <= w_rreq_nxt;
            r_ovf     <= w_ovf_nxt;
            r_lfail   <= w_lfail_nxt;
        end
    end

    assign o_state            = r_state;
    assign o_expected_address = r_exp;
    assign o_zbt_address      = r_zaddr;
    assign o_data_to_zbt      = r_zdata;
    assign o_resend_address   = r_raddr;
    assign o_good_count       = r_good;
    assign o_bad_count        = r_bad;
    assign o_write_enable     = r_we;
    assign o_resend_req       = r_rreq;
    assign o_overflow         = r_ovf;
    assign o_link_fail        = r_lfail;

endmodule

// File: tb/tb_stream_receiver_ctrl.sv
// Directed bench for stream_receiver_ctrl with small widths so address wrap and timeout are reachable.
module tb_stream_receiver_ctrl;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int CW = 4;
    localparam int PW = AW + DW + CW;
    localparam int MAXR = 3;
    localparam int TMO = 20;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          receive_en = 1'b0;
    logic          pkt_valid = 1'b0;
    logic [PW-1:0] pkt = '0;
    logic          crc_good = 1'b0;
    logic          memory_full = 1'b0;
    logic          wr_ready = 1'b0;
    logic          resend_ack = 1'b0;
    logic          write_enable;
    logic [AW-1:0] zbt_address;
    logic [DW-1:0] data_to_zbt;
    logic          resend_req;
    logic [AW-1:0] resend_address;
    logic [2:0]    state;
    logic [AW-1:0] expected_address;
    logic [15:0]   good_count;
    logic [15:0]   bad_count;
    logic          overflow;
    logic          link_fail;

    int checks = 0;
    int failures = 0;

    stream_receiver_ctrl #(
        .ADDR_W(AW), .DATA_W(DW), .CRC_W(CW), .MAX_RETRY(MAXR), .TIMEOUT(TMO)
    ) dut (
        .i_clk(clk), .i_reset(reset), .i_receive_en(receive_en),
        .i_pkt_valid(pkt_valid), .i_pkt(pkt), .i_crc_good(crc_good),
        .i_memory_full(memory_full), .i_wr_ready(wr_ready),
        .o_write_enable(write_enable), .o_zbt_address(zbt_address),
        .o_data_to_zbt(data_to_zbt), .o_resend_req(resend_req),
        .o_resend_address(resend_address), .i_resend_ack(resend_ack),
        .o_state(state), .o_expected_address(expected_address),
        .o_good_count(good_count), .o_bad_count(bad_count),
        .o_overflow(overflow), .o_link_fail(link_fail)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          en, pv;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          crc, mf, rdy, ack;
        logic [2:0]    st;
        logic          we;
        logic [AW-1:0] za;
        logic [DW-1:0] zd;
        logic          rq;
        logic [AW-1:0] ra;
        logic [AW-1:0] ea;
        logic [15:0]   gc, bc;
        logic          ov;
    } vec_t;

    vec_t vecs [13];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_pkt(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic c);
        pkt_valid = 1'b1;
        pkt       = {a, d, 4'hA};
        crc_good  = c;
    endtask

    task automatic clr_pkt();
        pkt_valid = 1'b0;
        pkt       = '0;
        crc_good  = 1'b0;
    endtask

    initial begin
        int n;
        logic [AW-1:0] hold_a;
        logic [DW-1:0] hold_d;

        //           en  pv  addr   data   crc mf  rdy ack   st  we  za    zd     rq  ra    ea    gc     bc     ov
        vecs[0]  = '{1'b1,1'b0,4'd0,8'h00,1'b0,1'b0,1'b1,1'b0, 3'd1,1'b0,4'd0,8'h00,1'b0,4'd0,4'd0,16'd0,16'd0,1'b0};
        vecs[1]  = '{1'b1,1'b1,4'd0,8'hA1,1'b1,1'b0,1'b1,1'b0, 3'd2,1'b1,4'd0,8'hA1,1'b0,4'd0,4'd0,16'd0,16'd0,1'b0};
        vecs[2]  = '{1'b1,1'b0,4'd0,8'h00,1'b0,1'b0,1'b1,1'b0, 3'd1,1'b0,4'd0,8'hA1,1'b0,4'd0,4'd1,16'd1,16'd0,1'b0};
        vecs[3]  = '{1'b1,1'b1,4'd1,8'hB2,1'b1,1'b0,1'b1,1'b0, 3'd2,1'b1,4'd1,8'hB2,1'b0,4'd0,4'd1,16'd1,16'd0,1'b0};
        vecs[4]  = '{1'b1,1'b0,4'd0,8'h00,1'b0,1'b0,1'b1,1'b0, 3'd1,1'b0,4'd1,8'hB2,1'b0,4'd0,4'd2,16'd2,16'd0,1'b0};
        vecs[5]  = '{1'b1,1'b1,4'd2,8'hC3,1'b1,1'b0,1'b1,1'b0, 3'd2,1'b1,4'd2,8'hC3,1'b0,4'd0,4'd2,16'd2,16'd0,1'b0};
        vecs[6]  = '{1'b1,1'b0,4'd0,8'h00,1'b0,1'b0,1'b1,1'b0, 3'd1,1'b0,4'd2,8'hC3,1'b0,4'd0,4'd3,16'd3,16'd0,1'b0};
        vecs[7]  = '{1'b1,1'b1,4'd3,8'hD4,1'b0,1'b0,1'b1,1'b0, 3'd3,1'b0,4'd2,8'hC3,1'b1,4'd3,4'd3,16'd3,16'd1,1'b0};
        vecs[8]  = '{1'b1,1'b0,4'd0,8'h00,1'b0,1'b0,1'b1,1'b0, 3'd3,1'b0,4'd2,8'hC3,1'b1,4'd3,4'd3,16'd3,16'd1,1'b0};
        vecs[9]  = '{1'b1,1'b0,4'd0,8'h00,1'b0,1'b0,1'b1,1'b1, 3'd1,1'b0,4'd2,8'hC3,1'b0,4'd3,4'd3,16'd3,16'd1,1'b0};
        vecs[10] = '{1'b1,1'b1,4'd3,8'hE5,1'b1,1'b1,1'b1,1'b0, 3'd1,1'b0,4'd2,8'hC3,1'b0,4'd3,4'd3,16'd3,16'd2,1'b1};
        vecs[11] = '{1'b1,1'b1,4'd3,8'hE5,1'b1,1'b0,1'b1,1'b0, 3'd2,1'b1,4'd3,8'hE5,1'b0,4'd3,4'd3,16'd3,16'd2,1'b1};
        vecs[12] = '{1'b1,1'b0,4'd0,8'h00,1'b0,1'b0,1'b1,1'b0, 3'd1,1'b0,4'd3,8'hE5,1'b0,4'd3,4'd4,16'd4,16'd2,1'b1};

        reset = 1'b1;
        step();
        step();
        chk("rst_state", state, 3'd0);
        chk("rst_we", write_enable, 1'b0);
        chk("rst_rreq", resend_req, 1'b0);
        chk("rst_exp", expected_address, 4'd0);
        chk("rst_counts", {good_count, bad_count}, 32'd0);
        chk("rst_flags", {overflow, link_fail}, 2'b00);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            receive_en  = vecs[i].en;
            pkt_valid   = vecs[i].pv;
            pkt         = {vecs[i].addr, vecs[i].data, 4'h5};
            crc_good    = vecs[i].crc;
            memory_full = vecs[i].mf;
            wr_ready    = vecs[i].rdy;
            resend_ack  = vecs[i].ack;
            step();
            chk($sformatf("v%0d_state", i), state, vecs[i].st);
            chk($sformatf("v%0d_we", i), write_enable, vecs[i].we);
            chk($sformatf("v%0d_zaddr", i), zbt_address, vecs[i].za);
            chk($sformatf("v%0d_zdata", i), data_to_zbt, vecs[i].zd);
            chk($sformatf("v%0d_rreq", i), resend_req, vecs[i].rq);
            chk($sformatf("v%0d_raddr", i), resend_address, vecs[i].ra);
            chk($sformatf("v%0d_exp", i), expected_address, vecs[i].ea);
            chk($sformatf("v%0d_good", i), good_count, vecs[i].gc);
            chk($sformatf("v%0d_bad", i), bad_count, vecs[i].bc);
            chk($sformatf("v%0d_ovf", i), overflow, vecs[i].ov);
        end
        clr_pkt();
        resend_ack  = 1'b0;
        memory_full = 1'b0;

        // Stalled write: wr_ready low for 5 cycles, stray packet dropped mid-write.
        wr_ready = 1'b0;
        set_pkt(4'd4, 8'h5A, 1'b1);
        step();
        clr_pkt();
        hold_a = 4'd4;
        hold_d = 8'h5A;
        n = 0;
        while (write_enable && n < 20) begin
            chk("stall_zaddr", zbt_address, hold_a);
            chk("stall_zdata", data_to_zbt, hold_d);
            wr_ready = (n >= 5);
            if (n == 2) set_pkt(4'd9, 8'h77, 1'b1);
            else clr_pkt();
            n++;
            step();
        end
        clr_pkt();
        chk("stall_we_cycles", n, 6);
        chk("stall_exp", expected_address, 4'd5);
        chk("stall_good", good_count, 16'd5);
        chk("stall_bad", bad_count, 16'd3);
        chk("stall_state", state, 3'd1);

        // Bad CRC, gap and duplicate, each acked: third retry without progress fails the link.
        set_pkt(4'd5, 8'h11, 1'b0);
        step();
        clr_pkt();
        for (int k = 0; k < 3; k++) begin
            chk("crc_rreq_hold", resend_req, 1'b1);
            chk("crc_raddr_hold", resend_address, 4'd5);
            step();
        end
        resend_ack = 1'b1;
        step();
        resend_ack = 1'b0;
        chk("crc_ack_state", state, 3'd1);
        chk("crc_ack_rreq", resend_req, 1'b0);
        set_pkt(4'd7, 8'h22, 1'b1);
        step();
        clr_pkt();
        chk("gap_rreq", resend_req, 1'b1);
        chk("gap_raddr", resend_address, 4'd5);
        chk("gap_bad", bad_count, 16'd5);
        resend_ack = 1'b1;
        step();
        resend_ack = 1'b0;
        set_pkt(4'd4, 8'h33, 1'b1);
        step();
        clr_pkt();
        chk("dup_rreq", resend_req, 1'b1);
        chk("dup_raddr", resend_address, 4'd5);
        resend_ack = 1'b1;
        step();
        resend_ack = 1'b0;
        chk("fail_state", state, 3'd4);
        chk("fail_link", link_fail, 1'b1);
        chk("fail_bad", bad_count, 16'd6);
        set_pkt(4'd5, 8'h44, 1'b1);
        step();
        clr_pkt();
        step();
        chk("fail_no_write", write_enable, 1'b0);
        chk("fail_stays", state, 3'd4);
        chk("fail_exp", expected_address, 4'd5);

        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst2_state", state, 3'd0);
        chk("rst2_link", {link_fail, overflow, resend_req}, 3'b000);
        chk("rst2_counts", {good_count, bad_count}, 32'd0);

        // Walk the address space to the all-ones address and check the wrap.
        receive_en = 1'b1;
        wr_ready   = 1'b1;
        step();
        for (int a = 0; a < 15; a++) begin
            set_pkt(4'(a), 8'(a + 16), 1'b1);
            step();
            clr_pkt();
            step();
        end
        chk("wrap_pre_exp", expected_address, 4'd15);
        set_pkt(4'd15, 8'hF0, 1'b1);
        step();
        clr_pkt();
        chk("wrap_we", write_enable, 1'b1);
        chk("wrap_zaddr", zbt_address, 4'd15);
        chk("wrap_zdata", data_to_zbt, 8'hF0);
        step();
        chk("wrap_exp", expected_address, 4'd0);
        chk("wrap_good", good_count, 16'd16);

        // No packets: resend of the expected address after TMO idle cycles.
        n = 0;
        while (!resend_req && n < 100) begin
            step();
            n++;
        end
        chk("timeout_cycles", n, TMO);
        chk("timeout_state", state, 3'd3);
        chk("timeout_raddr", resend_address, 4'd0);
        resend_ack = 1'b1;
        step();
        resend_ack = 1'b0;
        chk("timeout_ack_state", state, 3'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
